// File: rtl/scroll_sequencer.sv
// Scroll sequencer: 4-bit move counter advanced by a free-running prescaler
// (AUTO) and by debounced push-button presses. Optional SCROLL_REVERSE_EN macro adds reverse stepping via dir.
module scroll_sequencer #(
  parameter logic [31:0] PRESCALE        = 32'd50_000_000,
  parameter logic [23:0] DEBOUNCE_CYCLES = 24'd1_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic       btn_step,
  input  logic       dir,
  output logic [3:0] counter,
  output logic       step_pulse,
  output logic [1:0] mode
);

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    AUTO      = 2'b01,
    AUTO_HOLD = 2'b10
  } state_t;

  logic        run_meta_q, run_meta_d;
  logic        run_sync_q, run_sync_d;
  logic        btn_meta_q, btn_meta_d;
  logic        btn_sync_q, btn_sync_d;
  logic [23:0] db_cnt_q, db_cnt_d;
  logic        btn_level_q, btn_level_d;
  logic        btn_prev_q, btn_prev_d;
  logic [31:0] presc_q, presc_d;
  state_t      state_q, state_d;
  logic [3:0]  counter_q, counter_d;
  logic        step_pulse_q, step_pulse_d;

  logic        press_req;
  logic        release_req;
  logic        auto_req;
  logic        step_req;
  logic [3:0]  counter_next;

  // Edges of the accepted level, one cycle after the debouncer commits it.
  assign press_req   = btn_level_q & ~btn_prev_q;
  assign release_req = ~btn_level_q & btn_prev_q;
  assign auto_req    = (state_q == AUTO) && (presc_q == PRESCALE - 32'd1);
  assign step_req    = auto_req | press_req;

`ifdef SCROLL_REVERSE_EN
  assign counter_next = dir ? (counter_q - 4'd1) : (counter_q + 4'd1);
`else
  logic unused_dir;
  assign unused_dir   = dir;
  assign counter_next = counter_q + 4'd1;
`endif

  always_comb begin
    run_meta_d   = run;
    run_sync_d   = run_meta_q;
    btn_meta_d   = btn_step;
    btn_sync_d   = btn_meta_q;
    btn_prev_d   = btn_level_q;
    db_cnt_d     = db_cnt_q;
    btn_level_d  = btn_level_q;
    state_d      = state_q;
    presc_d      = presc_q;
    counter_d    = counter_q;
    step_pulse_d = step_req;

    // Debouncer: count consecutive samples disagreeing with the accepted level.
    if (btn_sync_q == btn_level_q) begin
      db_cnt_d = 24'd0;
    end else if (db_cnt_q == DEBOUNCE_CYCLES - 24'd1) begin
      db_cnt_d    = 24'd0;
      btn_level_d = btn_sync_q;
    end else begin
      db_cnt_d = db_cnt_q + 24'd1;
    end

    case (state_q)
      IDLE: begin
        if (run_sync_q) state_d = AUTO;
      end
      AUTO: begin
        if (!run_sync_q)    state_d = IDLE;
        else if (press_req) state_d = AUTO_HOLD;
      end
      AUTO_HOLD: begin
        if (!run_sync_q)      state_d = IDLE;
        else if (release_req) state_d = AUTO;
      end
      default: state_d = IDLE;
    endcase

    // Prescaler runs only while staying in AUTO; frozen while held.
    if (state_q == AUTO_HOLD && state_d == AUTO_HOLD) begin
      presc_d = presc_q;
    end else if (state_q != AUTO || state_d != AUTO || step_req) begin
      presc_d = 32'd0;
    end else begin
      presc_d = presc_q + 32'd1;
    end

    if (step_req) counter_d = counter_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_meta_q   <= 1'b0;
      run_sync_q   <= 1'b0;
      btn_meta_q   <= 1'b0;
      btn_sync_q   <= 1'b0;
      db_cnt_q     <= 24'd0;
      btn_level_q  <= 1'b0;
      btn_prev_q   <= 1'b0;
      presc_q      <= 32'd0;
      state_q      <= IDLE;
      counter_q    <= 4'd0;
      step_pulse_q <= 1'b0;
    end else begin
      run_meta_q   <= run_meta_d;
      run_sync_q   <= run_sync_d;
      btn_meta_q   <= btn_meta_d;
      btn_sync_q   <= btn_sync_d;
      db_cnt_q     <= db_cnt_d;
      btn_level_q  <= btn_level_d;
      btn_prev_q   <= btn_prev_d;
      presc_q      <= presc_d;
      state_q      <= state_d;
      counter_q    <= counter_d;
      step_pulse_q <= step_pulse_d;
    end
  end

  assign counter    = counter_q;
  assign step_pulse = step_pulse_q;
  assign mode       = state_q;

endmodule

// File: doc/scroll_sequencer.md
SCROLL_SEQUENCER -- requirements
Module: scroll_sequencer

Interface
REQ-001 The block SHALL take parameter PRESCALE, default 50000000: clk cycles per automatic scroll step, legal range 2 to 2^32-1.
REQ-002 The block SHALL take parameter DEBOUNCE_CYCLES, default 1000000: consecutive stable synchronized samples needed to accept a button level, legal range 1 to 2^24-1.
REQ-003 The block SHALL have port clk, input, 1 bit: system clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port run, input, 1 bit: asynchronous switch level; 1 selects automatic scrolling.
REQ-006 The block SHALL have port btn_step, input, 1 bit: asynchronous raw push-button; each accepted press produces one manual step.
REQ-007 The block SHALL have port dir, input, 1 bit: 0 selects forward scrolling, 1 selects reverse; it is honoured only per REQ-027.
REQ-008 The block SHALL have port counter, output, 4 bits: move number driving the character-window memory.
REQ-009 The block SHALL have port step_pulse, output, 1 bit: high for exactly one cycle in the cycle in which counter takes a new value.
REQ-010 The block SHALL have port mode, output, 2 bits: current state encoding, with IDLE=00, AUTO=01, AUTO_HOLD=10.

Function
REQ-011 run and btn_step SHALL each pass through a 2-flop synchronizer before use; dir SHALL be sampled directly.
REQ-012 The top-level FSM SHALL have three states:
- IDLE: no automatic steps.
- AUTO: the prescaler counts and steps on terminal count.
- AUTO_HOLD: entered from AUTO while an accepted press is held; the prescaler is frozen.
REQ-013 The FSM transitions SHALL be:
- IDLE->AUTO when run_sync=1.
- AUTO->IDLE when run_sync=0.
- AUTO->AUTO_HOLD on an accepted press.
- AUTO_HOLD->AUTO on an accepted release while run_sync=1.
- AUTO_HOLD->IDLE when run_sync=0.
REQ-014 The prescaler SHALL be cleared on entry to AUTO and on every step; in AUTO it SHALL raise an auto-step request when it reaches PRESCALE-1.
REQ-015 The first auto step SHALL occur exactly PRESCALE+2 cycles after run rises, given no button activity; later steps SHALL follow every PRESCALE cycles.
REQ-016 The debouncer SHALL hold a separate accepted button level, initially 0. It SHALL change that level only after DEBOUNCE_CYCLES consecutive synchronized samples equal to the opposite level. Any mismatching sample SHALL clear its count.
REQ-017 A 0->1 change of the accepted level (an accepted press) SHALL raise exactly one manual-step request, in any state; holding the button SHALL never repeat it.
REQ-018 A manual step SHALL update counter exactly DEBOUNCE_CYCLES+2 cycles after btn_step rises, given btn_step is held stable.
REQ-019 A forward step SHALL set counter to counter+1 modulo 16 (15->0); a reverse step SHALL set counter to counter-1 modulo 16 (0->15).
REQ-020 Auto-step and manual-step requests in the same cycle SHALL produce a single step of 1, with one step_pulse.
REQ-021 A manual step in AUTO SHALL clear the prescaler, so the next auto step follows PRESCALE cycles later.
REQ-022 Leaving AUTO SHALL clear the prescaler; counter SHALL hold its value in IDLE.
REQ-023 run toggling while the button is held SHALL NOT re-trigger a manual step.

Reset
REQ-024 While reset=1, the block SHALL asynchronously force: counter=0, step_pulse=0, mode=IDLE, prescaler=0, debounce count=0, accepted button level=0, and all synchronizer flops=0.
REQ-025 On release of reset, the block SHALL treat a button already held as a new press once it has been stable for DEBOUNCE_CYCLES.
REQ-026 Reset asserted mid-count SHALL discard any pending step; no step_pulse SHALL appear in the cycle after reset is released.

Configuration
REQ-027 Macro SCROLL_REVERSE_EN SHALL control reverse scrolling:
- Defined: dir selects direction per REQ-019, sampled in the step cycle.
- Undefined: dir is ignored, every step is forward, and no reverse decrement logic is synthesized.

Verification (bench: PRESCALE=4, DEBOUNCE_CYCLES=3)
REQ-028 reset pulse, then run=0 and btn_step=0 for 20 cycles -> counter=0, step_pulse never 1, mode=00.
REQ-029 run=1 at cycle 0 -> step_pulse at cycles 6, 10, 14; counter 1, 2, 3; mode=01.
REQ-030 run=0, counter=15, btn_step held high 10 cycles -> single step at cycle 5 to counter=0; no further steps. btn_step glitch of 2 cycles -> no step.
REQ-031 SCROLL_REVERSE_EN defined, dir=1, counter=0, one accepted press -> counter=15. Same stimulus with the macro undefined -> counter=1.
REQ-032 run=1 with an accepted press landing on the prescaler terminal cycle -> counter advances by exactly 1; mode=10 while the button is held; auto steps resume PRESCALE cycles after release.
REQ-033 Reset asserted mid-scroll at counter=7 -> counter=0 immediately (asynchronous). After release with run=1 -> first step at cycle 6.
